// File: rtl/data_mem_responder_if.sv
// Data-port bus between the CPU core (master) and data_mem_responder (slave),
// plus the write-trace drain port. The optional range_err output exists only
// when DM_RANGE_CHECK_EN is defined.
interface data_mem_responder_if #(
  parameter int TRACE_DEPTH = 8
);
  logic [31:0]                  m_data_addr;
  logic [31:0]                  m_data_wdata;
  logic [3:0]                   m_data_byteen;
  logic [31:0]                  m_inst_addr;
  logic [31:0]                  m_data_rdata;
  logic                         trace_valid;
  logic                         trace_ready;
  logic [31:0]                  trace_pc;
  logic [31:0]                  trace_addr;
  logic [31:0]                  trace_data;
  logic [$clog2(TRACE_DEPTH):0] trace_count;
  logic                         trace_overflow;
`ifdef DM_RANGE_CHECK_EN
  logic                         range_err;
`endif

  modport master (
`ifdef DM_RANGE_CHECK_EN
    input  range_err,
`endif
    output m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, trace_ready,
    input  m_data_rdata, trace_valid, trace_pc, trace_addr, trace_data,
           trace_count, trace_overflow
  );

  modport slave (
`ifdef DM_RANGE_CHECK_EN
    output range_err,
`endif
    input  m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, trace_ready,
    output m_data_rdata, trace_valid, trace_pc, trace_addr, trace_data,
           trace_count, trace_overflow
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder: combinational reads, byte-enabled write commits, and
// a circular trace FIFO holding {PC, word address, merged word} per write.
// Optional macro DM_RANGE_CHECK_EN: out-of-range accesses read 0, writes are
// dropped, and a sticky range_err flag is raised.
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 12,
  parameter int TRACE_DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  data_mem_responder_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = $clog2(TRACE_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_rec_t;

  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           old_word;
  logic [31:0]           merged;
  logic                  wr_en;
  logic                  unused_addr;

  assign idx         = bus.m_data_addr[ADDR_WIDTH+1:2];
  assign old_word    = mem[idx];
  assign unused_addr = ^bus.m_data_addr[1:0];

  // Per-lane merge of new write data over the current word
  for (genvar l = 0; l < 4; l++) begin : g_lane
    assign merged[8*l +: 8] = bus.m_data_byteen[l] ? bus.m_data_wdata[8*l +: 8]
                                                   : old_word[8*l +: 8];
  end

`ifdef DM_RANGE_CHECK_EN
  logic oor;
  logic range_err_q;
  assign oor              = |bus.m_data_addr[31:ADDR_WIDTH+2];
  assign wr_en            = (|bus.m_data_byteen) && !oor;
  assign bus.m_data_rdata = oor ? 32'h0 : old_word;
  assign bus.range_err    = range_err_q;

  // Sticky flag: any access (read or write) seen with an out-of-range address
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   range_err_q <= 1'b0;
    else if (oor) range_err_q <= 1'b1;
  end
`else
  assign wr_en            = |bus.m_data_byteen;
  assign bus.m_data_rdata = old_word;
`endif

  // Memory array: cleared on reset, merged word committed on write edges
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[idx] <= merged;
    end
  end

  // Trace FIFO control
  trace_rec_t    fifo [TRACE_DEPTH];
  trace_rec_t    head;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;
  logic          empty, full, pop, push, ovf_q;

  assign empty = (count == '0);
  assign full  = (count == (PW+1)'(TRACE_DEPTH));
  assign pop   = !empty && bus.trace_ready;
  // When full, a simultaneous pop frees the slot the push needs.
  assign push  = wr_en && (!full || pop);
  assign head  = fifo[rd_ptr];

  // Record storage needs no reset: pointers and count define validity
  always_ff @(posedge clk) begin
    if (push && reset)
      fifo[wr_ptr] <= '{pc: bus.m_inst_addr, addr: {bus.m_data_addr[31:2], 2'b00}, data: merged};
  end

  // Pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      if (wr_en && !push) ovf_q <= 1'b1;
    end
  end

  assign bus.trace_valid    = !empty;
  assign bus.trace_count    = count;
  assign bus.trace_overflow = ovf_q;
  assign bus.trace_pc       = empty ? 32'h0 : head.pc;
  assign bus.trace_addr     = empty ? 32'h0 : head.addr;
  assign bus.trace_data     = empty ? 32'h0 : head.data;
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the CPU core's data port.
- Serves `m_data_rdata` for the core's `m_data_addr` and commits byte-enabled writes from `m_data_wdata`/`m_data_byteen`.
- Pushes one trace record per committed write (PC, word address, resulting full word) into an internal FIFO, drained by a ready/valid port.
- Sits beside the core at system top; replaces the bench-side data memory and feeds the write-trace checker.

Parameters:
- ADDR_WIDTH, 12, word-address bits; depth = 2^ADDR_WIDTH 32-bit words (16 KiB at default).
- TRACE_DEPTH, 8, trace FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- m_data_addr  input  32  byte address from core; bits [1:0] ignored.
- m_data_wdata  input  32  write data, already lane-aligned by the core.
- m_data_byteen  input  4  byte lane write enables; 4'b0000 = read/idle.
- m_inst_addr  input  32  PC of the instruction issuing the access.
- m_data_rdata  output  32  read data for m_data_addr.
- trace_valid  output  1  FIFO head holds a record.
- trace_ready  input  1  consumer accepts head when high together with trace_valid.
- trace_pc  output  32  PC of head record.
- trace_addr  output  32  word-aligned byte address of head record, bits [1:0] = 0.
- trace_data  output  32  full word in memory after that write.
- trace_count  output  $clog2(TRACE_DEPTH)+1  current FIFO occupancy.
- trace_overflow  output  1  sticky: a record was dropped because the FIFO was full.

Behaviour:
- Word index = m_data_addr[ADDR_WIDTH+1:2].
- Reset (reset low, asynchronous):
  - all memory words = 0;
  - FIFO emptied: trace_valid = 0, trace_count = 0;
  - trace_overflow = 0;
  - trace_pc, trace_addr and trace_data read 0 while empty.
- Read path:
  - m_data_rdata = mem[index], combinational, zero-cycle latency.
  - Independent of m_data_byteen.
  - In a write cycle it shows the pre-write word; the new word is visible after the edge.
- Write commit, on the rising edge when m_data_byteen != 0:
  - lane i (bits 8i+7:8i) takes m_data_wdata lane i when byteen[i] = 1, otherwise keeps the old value;
  - non-contiguous enables (e.g. 4'b1001) are honoured as given.
- Trace push, same edge as the commit:
  - record = {m_inst_addr, {m_data_addr[31:2], 2'b00}, merged word};
  - occupancy +1.
- Trace pop: on the edge where trace_valid && trace_ready; occupancy -1.
- FIFO organisation: circular buffer with read/write pointers that wrap modulo TRACE_DEPTH; head outputs are driven combinationally from the read pointer.
- Simultaneous push and pop:
  - empty: push only (no bypass; trace_valid rises the next cycle);
  - full: pop and push both accepted, occupancy stays TRACE_DEPTH, no overflow;
  - otherwise: occupancy unchanged.
- Push when full without a pop:
  - record dropped; memory write still commits;
  - trace_overflow set to 1, cleared only by reset.
- Back-to-back writes to the same word on consecutive cycles: the second merge uses the word committed by the first.
- Reset asserted mid-stream: pending FIFO contents are discarded immediately; no partial write commits on the edge coincident with reset low.

Optional Feature:
- Macro: DM_RANGE_CHECK_EN.
- Defined:
  - an access is out of range when m_data_addr[31:ADDR_WIDTH+2] != 0;
  - out-of-range writes are dropped (no memory change, no trace push);
  - out-of-range reads return 32'h0000_0000;
  - extra output port range_err (1 bit) goes sticky high on the first out-of-range write or read with byteen = 0 while the address is out of range; cleared by reset.
- Not defined: upper address bits are ignored (address wraps modulo depth) and port range_err does not exist.

Test Plan:
- Reset, then read address 0x0000_0010 with byteen 0 -> m_data_rdata = 0, trace_valid = 0, trace_count = 0.
- Write 0x1234_5678 to 0x0000_0004, byteen 4'b1111, m_inst_addr 0x0000_3000, trace_ready = 0 -> next cycle:
  - m_data_rdata = 0x1234_5678 at that address;
  - trace_valid = 1, trace_pc = 0x0000_3000, trace_addr = 0x0000_0004, trace_data = 0x1234_5678.
- Over that word, write 0x00AB_0000 with byteen 4'b0100 at address 0x0000_0006 -> word = 0x12AB_5678; trace_addr = 0x0000_0004.
- Hold trace_ready = 0 and issue TRACE_DEPTH+1 = 9 writes:
  - trace_count = 8, trace_overflow = 1;
  - the 9th word is still written to memory;
  - draining yields the first 8 records in order.
- With the FIFO full, issue a write while trace_ready = 1 -> count stays 8, trace_overflow unchanged, the new record lands at the tail.
- With DM_RANGE_CHECK_EN, ADDR_WIDTH = 12: write to 0x0000_4000 -> no memory change, no push, range_err = 1. Without the macro, the same write lands at word 0.
